// File: rtl/loop_branch_decoder.sv
// Loop/branch decoder for the program counter.
// Decodes the instruction at the current pc and drives the pc redirect
// controls (branch, loop start). A shadow copy of the pc's loop progress
// tracks when a loop is active. Illegal and nested LOOP words are flagged.
module loop_branch_decoder #(
    parameter int unsigned     INSTR_W    = 16,
    parameter int unsigned     ADDR_W     = 4,
    parameter logic [3:0]      OPC_BRANCH = 4'hA,
    parameter logic [3:0]      OPC_LOOP   = 4'hB
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                instr_valid,
    input  logic                err_clr,
    output logic                branch_en,
    output logic [ADDR_W-1:0]   target_address,
    output logic                loop_en,
    output logic [ADDR_W-1:0]   line_count,
    output logic [ADDR_W-1:0]   repetation_count,
    output logic                in_loop,
    output logic [ADDR_W-1:0]   iter_count,
    output logic                err_pulse,
    output logic                err_sticky
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOOP = 1'b1;

    // Instruction fields
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] lc_fld;
    logic [ADDR_W-1:0] rc_fld;

    // Decode results
    logic is_br;
    logic is_lp;
    logic lp_fields_ok;
    logic err_d;

    // Registered state
    logic [0:0]        state_q,      state_d;
    logic [ADDR_W-1:0] body_cnt_q,   body_cnt_d;
    logic [ADDR_W-1:0] iter_cnt_q,   iter_cnt_d;
    logic [ADDR_W-1:0] line_cnt_q,   line_cnt_d;
    logic [ADDR_W-1:0] rep_cnt_q,    rep_cnt_d;
    logic              err_pulse_q;
    logic              err_sticky_q, err_sticky_d;

    // One bit wider so the iteration comparison cannot wrap at the maximum count
    logic [ADDR_W:0]   iter_next_wide;
    logic [ADDR_W:0]   rep_wide;

    assign opcode = instr[INSTR_W-1:INSTR_W-4];
    assign lc_fld = instr[2*ADDR_W-1:ADDR_W];
    assign rc_fld = instr[ADDR_W-1:0];

    // Bits between the opcode and the loop fields carry no meaning here
    generate
        if (INSTR_W - 4 > 2 * ADDR_W) begin : g_unused
            logic unused_instr_bits;
            assign unused_instr_bits = ^instr[INSTR_W-5:2*ADDR_W];
        end
    endgenerate

    // Combinational decode and redirect controls
    always_comb begin
        is_br        = instr_valid && (opcode == OPC_BRANCH);
        is_lp        = instr_valid && (opcode == OPC_LOOP);
        lp_fields_ok = (lc_fld != '0) && (rc_fld != '0);
        branch_en    = is_br;
        target_address = instr[ADDR_W-1:0];
        loop_en      = is_lp && (state_q == ST_IDLE) && lp_fields_ok && !is_br;
        // Illegal in IDLE (zero field) or any LOOP word while a loop is active
        err_d        = is_lp && ((state_q == ST_LOOP) || !lp_fields_ok);
    end

    // Next-state logic for the shadow loop tracker
    always_comb begin
        state_d        = state_q;
        body_cnt_d     = body_cnt_q;
        iter_cnt_d     = iter_cnt_q;
        line_cnt_d     = line_cnt_q;
        rep_cnt_d      = rep_cnt_q;
        iter_next_wide = {1'b0, iter_cnt_q} + {{ADDR_W{1'b0}}, 1'b1};
        rep_wide       = {1'b0, rep_cnt_q};

        case (state_q)
            ST_IDLE: begin
                if (loop_en) begin
                    line_cnt_d = lc_fld;
                    rep_cnt_d  = rc_fld;
                    body_cnt_d = {{(ADDR_W-1){1'b0}}, 1'b1};
                    iter_cnt_d = '0;
                    state_d    = ST_LOOP;
                end
            end
            ST_LOOP: begin
                if (branch_en) begin
                    // pc abandons the loop; overrides any wrap or exit this cycle
                    state_d    = ST_IDLE;
                    body_cnt_d = '0;
                    iter_cnt_d = '0;
                end else if (body_cnt_q < line_cnt_q) begin
                    body_cnt_d = body_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else if (iter_next_wide < rep_wide) begin
                    iter_cnt_d = iter_next_wide[ADDR_W-1:0];
                    body_cnt_d = {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d    = ST_IDLE;
                    body_cnt_d = '0;
                    iter_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                body_cnt_d = '0;
                iter_cnt_d = '0;
            end
        endcase
    end

    // Sticky error: a new error wins over a same-cycle clear
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (err_d) begin
            err_sticky_d = 1'b1;
        end else if (err_clr) begin
            err_sticky_d = 1'b0;
        end
    end

    // State and output registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            body_cnt_q   <= '0;
            iter_cnt_q   <= '0;
            line_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            body_cnt_q   <= body_cnt_d;
            iter_cnt_q   <= iter_cnt_d;
            line_cnt_q   <= line_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            err_pulse_q  <= err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Registered outputs
    always_comb begin
        line_count       = line_cnt_q;
        repetation_count = rep_cnt_q;
        in_loop          = (state_q == ST_LOOP);
        iter_count       = iter_cnt_q;
        err_pulse        = err_pulse_q;
        err_sticky       = err_sticky_q;
    end

endmodule

// File: tb/tb_loop_branch_decoder.sv
// Directed bench for loop_branch_decoder: table of per-cycle vectors plus
// hand-written sequences for branch-out-of-loop and asynchronous reset.
module tb_loop_branch_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        err_clr;
    logic        branch_en;
    logic [3:0]  target_address;
    logic        loop_en;
    logic [3:0]  line_count;
    logic [3:0]  repetation_count;
    logic        in_loop;
    logic [3:0]  iter_count;
    logic        err_pulse;
    logic        err_sticky;

    int errors = 0;
    int checks = 0;

    loop_branch_decoder #(
        .INSTR_W    (16),
        .ADDR_W     (4),
        .OPC_BRANCH (4'hA),
        .OPC_LOOP   (4'hB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .err_clr          (err_clr),
        .branch_en        (branch_en),
        .target_address   (target_address),
        .loop_en          (loop_en),
        .line_count       (line_count),
        .repetation_count (repetation_count),
        .in_loop          (in_loop),
        .iter_count       (iter_count),
        .err_pulse        (err_pulse),
        .err_sticky       (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied, combinational outputs checked before the edge,
    // registered outputs checked after the edge.
    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        clr;
        logic        br;
        logic [3:0]  tgt;
        logic        le;
        logic [3:0]  line;
        logic [3:0]  rep;
        logic        inl;
        logic [3:0]  it;
        logic        ep;
        logic        es;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input int line, input int rep,
                              input int inl, input int it, input int ep, input int es);
        check({tag, ".line_count"},       int'(line_count),       line);
        check({tag, ".repetation_count"}, int'(repetation_count), rep);
        check({tag, ".in_loop"},          int'(in_loop),          inl);
        check({tag, ".iter_count"},       int'(iter_count),       it);
        check({tag, ".err_pulse"},        int'(err_pulse),        ep);
        check({tag, ".err_sticky"},       int'(err_sticky),       es);
    endtask

    // Drive at posedge+1, check combinational at posedge+2
    task automatic drive(input logic [15:0] w, input logic v, input logic c);
        instr       = w;
        instr_valid = v;
        err_clr     = c;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [15:0] w, input logic v, input logic c,
                                input logic br, input logic [3:0] tgt, input logic le,
                                input logic [3:0] line, input logic [3:0] rep,
                                input logic inl, input logic [3:0] it,
                                input logic ep, input logic es);
        vec_t r;
        r.instr = w; r.valid = v; r.clr = c; r.br = br; r.tgt = tgt; r.le = le;
        r.line = line; r.rep = rep; r.inl = inl; r.it = it; r.ep = ep; r.es = es;
        return r;
    endfunction

    initial begin
        //            instr     v  c  br tgt le | line rep inl it ep es
        // Branch, then same word with instr_valid low
        vecs[0]  = mk(16'hA007, 1, 0, 1, 7, 0,   0,  0,  0,  0, 0, 0);
        vecs[1]  = mk(16'hA007, 0, 0, 0, 7, 0,   0,  0,  0,  0, 0, 0);
        // Basic loop B023: 2-line body, 3 iterations -> 6 cycles in_loop
        vecs[2]  = mk(16'hB023, 1, 0, 0, 3, 1,   2,  3,  1,  0, 0, 0);
        vecs[3]  = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  0, 0, 0);
        vecs[4]  = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  1, 0, 0);
        vecs[5]  = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  1, 0, 0);
        vecs[6]  = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  2, 0, 0);
        vecs[7]  = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  2, 0, 0);
        vecs[8]  = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  0,  0, 0, 0);
        // Illegal loops (lc=0, rc=0), then clear; then clear vs. error same cycle
        vecs[9]  = mk(16'hB003, 1, 0, 0, 3, 0,   2,  3,  0,  0, 1, 1);
        vecs[10] = mk(16'hB030, 1, 0, 0, 0, 0,   2,  3,  0,  0, 1, 1);
        vecs[11] = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  0,  0, 0, 1);
        vecs[12] = mk(16'h0000, 1, 1, 0, 0, 0,   2,  3,  0,  0, 0, 0);
        vecs[13] = mk(16'hB003, 1, 1, 0, 3, 0,   2,  3,  0,  0, 1, 1);
        vecs[14] = mk(16'h0000, 1, 1, 0, 0, 0,   2,  3,  0,  0, 0, 0);
        // Nested LOOP on 2nd body cycle of a B023 loop; loop keeps its schedule
        vecs[15] = mk(16'hB023, 1, 0, 0, 3, 1,   2,  3,  1,  0, 0, 0);
        vecs[16] = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  0, 0, 0);
        vecs[17] = mk(16'hB011, 1, 0, 0, 1, 0,   2,  3,  1,  1, 1, 1);
        vecs[18] = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  1, 0, 1);
        vecs[19] = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  2, 0, 1);
        vecs[20] = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  1,  2, 0, 1);
        vecs[21] = mk(16'h0000, 1, 0, 0, 0, 0,   2,  3,  0,  0, 0, 1);
        // LOOP word with instr_valid low is a NOP
        vecs[22] = mk(16'hB023, 0, 0, 0, 3, 0,   2,  3,  0,  0, 0, 1);
        vecs[23] = mk(16'h0000, 1, 1, 0, 0, 0,   2,  3,  0,  0, 0, 0);
        // Single-line, single-iteration loop
        vecs[24] = mk(16'hB011, 1, 0, 0, 1, 1,   1,  1,  1,  0, 0, 0);

        rst = 1'b1;
        instr = '0;
        instr_valid = 1'b0;
        err_clr = 1'b0;
        #1;
        check_regs("reset", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].instr, vecs[i].valid, vecs[i].clr);
            check({tag, ".branch_en"},      int'(branch_en),      int'(vecs[i].br));
            check({tag, ".target_address"}, int'(target_address), int'(vecs[i].tgt));
            check({tag, ".loop_en"},        int'(loop_en),        int'(vecs[i].le));
            tick();
            check_regs(tag, vecs[i].line, vecs[i].rep, vecs[i].inl,
                       vecs[i].it, vecs[i].ep, vecs[i].es);
        end
        // B011 loop from vec24 exits after one cycle
        drive(16'h0000, 1, 0);
        tick();
        check_regs("b011_exit", 1, 1, 0, 0, 0, 0);

        // Branch on the last body instruction of the first iteration of B033
        drive(16'hB033, 1, 0);
        check("bil.loop_en", int'(loop_en), 1);
        tick();
        check_regs("bil.start", 3, 3, 1, 0, 0, 0);
        drive(16'h0000, 1, 0);
        tick();
        drive(16'h0000, 1, 0);
        tick();
        check_regs("bil.body3", 3, 3, 1, 0, 0, 0);
        drive(16'hA005, 1, 0);
        check("bil.branch_en", int'(branch_en), 1);
        check("bil.target", int'(target_address), 5);
        check("bil.loop_en0", int'(loop_en), 0);
        tick();
        check_regs("bil.after", 3, 3, 0, 0, 0, 0);
        drive(16'h0000, 1, 0);
        tick();
        check_regs("bil.idle", 3, 3, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a B0F2 loop
        drive(16'hB0F2, 1, 0);
        check("rml.loop_en", int'(loop_en), 1);
        tick();
        check_regs("rml.start", 15, 2, 1, 0, 0, 0);
        drive(16'h0000, 1, 0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_regs("rml.reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_regs("rml.released", 0, 0, 0, 0, 0, 0);
        drive(16'hB011, 1, 0);
        check("rml.loop_en", int'(loop_en), 1);
        tick();
        check_regs("rml.b011", 1, 1, 1, 0, 0, 0);
        drive(16'h0000, 1, 0);
        tick();
        check_regs("rml.b011_exit", 1, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/loop_branch_decoder.md
Name: loop_branch_decoder

Overview:
- Control-side counterpart of the program counter: decodes the instruction word fetched at the current pc and drives the counter's redirect inputs.
- Driven outputs: branch_en, loop_en, target_address, line_count, repetation_count.
- Keeps a shadow copy of the counter's loop progress, so it knows when a loop is active and holds the loop parameters stable for the whole loop.
- Sits between the combinational-read instruction memory and the pc register. It also flags illegal or nested loop instructions.

Parameters:
- INSTR_W, 16, instruction word width; opcode is in [INSTR_W-1:INSTR_W-4].
- ADDR_W, 4, width of pc, target_address, line_count, repetation_count.
- OPC_BRANCH, 4'hA, opcode for unconditional branch; target = instr[ADDR_W-1:0].
- OPC_LOOP, 4'hB, opcode for hardware loop; line count = instr[2*ADDR_W-1:ADDR_W], repetition count = instr[ADDR_W-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr  in  INSTR_W  instruction word read at current pc, same cycle.
- instr_valid  in  1  instr is valid; when low, instr is treated as NOP.
- err_clr  in  1  clears err_sticky.
- branch_en  out  1  combinational; redirect pc to target_address at the next edge.
- target_address  out  ADDR_W  combinational; instr[ADDR_W-1:0].
- loop_en  out  1  combinational; start a hardware loop at the next edge.
- line_count  out  ADDR_W  registered; loop body length.
- repetation_count  out  ADDR_W  registered; loop iteration count.
- in_loop  out  1  registered; shadow loop-active flag.
- iter_count  out  ADDR_W  registered; completed iterations of the current loop.
- err_pulse  out  1  registered; one-cycle pulse on an illegal or nested LOOP.
- err_sticky  out  1  registered; set by any error, cleared by err_clr.

Behaviour:
- Reset (asynchronous, any time, including mid-loop):
  - state=IDLE, in_loop=0, body_cnt=0, iter_count=0.
  - line_count=0, repetation_count=0, err_pulse=0, err_sticky=0.
- Decode, valid only when instr_valid=1:
  - is_br = opcode==OPC_BRANCH.
  - is_lp = opcode==OPC_LOOP.
  - All other opcodes are NOP for this block.
- branch_en = is_br, in any state.
- target_address always reflects instr[ADDR_W-1:0], whatever the opcode.
- loop_en = is_lp & state==IDLE & lc!=0 & rc!=0 & !is_br (lc, rc are the instruction fields).
- State IDLE:
  - On loop_en: latch line_count<=lc, repetation_count<=rc; set body_cnt<=1, iter_count<=0; go to LOOP.
  - These outputs are valid from the edge at which pc moves to the first body instruction, and stay stable until the next loop issue.
- State LOOP (advances every cycle, mirroring the pc; instr_valid does not stall it):
  - If body_cnt < line_count: body_cnt++.
  - Else: iter_count++.
    - If iter_count+1 < repetation_count: body_cnt<=1 (wrap to loop start).
    - Else: go to IDLE, body_cnt<=0, iter_count<=0.
- Branch priority: branch_en in LOOP state forces IDLE next edge, clearing body_cnt and iter_count. This mirrors the pc abandoning the loop. It overrides a same-cycle wrap or loop exit.
- Errors:
  - Illegal LOOP: is_lp in IDLE with lc==0 or rc==0. No loop_en; err_pulse=1 next cycle; err_sticky set.
  - Nested LOOP: is_lp while in LOOP. Ignored, no loop_en, error as above. Loop tracking continues unchanged.
- err_sticky: if err_clr and a new error occur in the same cycle, set wins.
- in_loop = (state==LOOP).
- Counter widths are ADDR_W. The maximum count of 15 must not wrap; comparisons are unsigned.

Test Plan:
- Branch: instr=16'hA007 in IDLE -> branch_en=1, target_address=7, loop_en=0, state stays IDLE; instr_valid=0 with the same word -> branch_en=0.
- Basic loop: instr=16'hB023 -> loop_en=1 one cycle. Next edge: line_count=2, repetation_count=3, in_loop=1. in_loop stays high for exactly 6 cycles (3 iterations x 2 body instructions), iter_count steps 0,1,2, then returns to 0.
- Illegal: instr=16'hB003 then 16'hB030 -> loop_en=0 for both; err_pulse high the cycle after each; err_sticky=1 until err_clr=1, then 0.
- Nested: inside a B023 loop, present 16'hB011 on the 2nd body cycle -> loop_en=0, err_pulse=1, loop still completes on schedule.
- Branch in loop: during B033, issue 16'hA005 on the last body instruction of iteration 1 -> branch_en=1, in_loop=0 next edge, iter_count=0.
- Reset mid-loop: assert rst asynchronously mid-B0F2 -> all registered outputs 0 immediately. After release, 16'hB011 is accepted normally.
